// File: rtl/mem_port_arbiter_pkg.sv
// Shared encodings for the IF/MEM RAM port arbiter: FSM states, owner codes,
// RAM access attributes and the alignment helper.
package mem_port_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_ACC  = 2'b01,
    ST_RESP = 2'b10
  } state_t;

  localparam logic OWN_IF    = 1'b0;
  localparam logic OWN_MEM   = 1'b1;
  localparam logic RW_READ   = 1'b0;
  localparam logic RW_WRITE  = 1'b1;
  localparam logic SIZE_BYTE = 1'b0;
  localparam logic SIZE_WORD = 1'b1;

  // Word accesses must sit on a 4-byte boundary; byte accesses never fault.
  function automatic logic is_misaligned(input logic size, input logic [1:0] addr_lo);
    return (size == SIZE_WORD) && (addr_lo != 2'b00);
  endfunction

endpackage

// File: rtl/mem_arb_lat_counter.sv
// Access-latency counter: cleared when an access is granted, counts while the
// RAM is enabled, and flags the final enable cycle.
module mem_arb_lat_counter #(
  parameter int LAT = 2
) (
  input  logic clk,
  input  logic R,
  input  logic clr,
  input  logic en,
  output logic done
);

  localparam logic [3:0] LAST = 4'(LAT - 1);

  logic [3:0] cnt;

  always_ff @(posedge clk) begin
    if (R) begin
      cnt <= 4'd0;
    end else if (clr) begin
      cnt <= 4'd0;
    end else if (en) begin
      cnt <= cnt + 4'd1;
    end
  end

  assign done = (cnt == LAST);

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one RAM port between instruction fetch and the load/store stage:
// MEM has priority, the just-served requester is masked for one cycle.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 32,
  parameter int LAT    = 2
) (
  input  logic              clk,
  input  logic              R,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_ack,
  input  logic              mem_req,
  input  logic              mem_rw,
  input  logic              mem_size,
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_wdata,
  output logic [DATA_W-1:0] mem_rdata,
  output logic              mem_ack,
  output logic              mem_err,
  output logic              ram_E,
  output logic              ram_RW,
  output logic              ram_Size,
  output logic [ADDR_W-1:0] ram_A,
  output logic [DATA_W-1:0] ram_DI,
  input  logic [DATA_W-1:0] ram_DO,
  output logic              stall_if,
  output logic              stall_mem,
  output logic              busy
);

  state_t state;
  logic   owner;
  logic   resp_mask;
  logic   mem_ok;
  logic   if_ok;
  logic   gnt_mem;
  logic   gnt_if;
  logic   misaligned;
  logic   lat_done;

  // In RESP the owner just acked still holds its request this cycle; masking it
  // keeps that stale request from being re-granted and makes contention alternate.
  always_comb begin
    resp_mask = (state == ST_RESP);
    mem_ok    = mem_req && !(resp_mask && owner == OWN_MEM);
    if_ok     = if_req  && !(resp_mask && owner == OWN_IF);
    gnt_mem   = 1'b0;
    gnt_if    = 1'b0;
    if (state == ST_IDLE || state == ST_RESP) begin
      gnt_mem = mem_ok;
      gnt_if  = if_ok && !mem_ok;
    end
  end

  assign misaligned = is_misaligned(mem_size, mem_addr[1:0]);

  mem_arb_lat_counter #(
    .LAT (LAT)
  ) u_lat (
    .clk  (clk),
    .R    (R),
    .clr  (gnt_mem || gnt_if),
    .en   (state == ST_ACC),
    .done (lat_done)
  );

  always_ff @(posedge clk) begin
    if (R) begin
      state     <= ST_IDLE;
      owner     <= OWN_IF;
      ram_E     <= 1'b0;
      ram_RW    <= RW_READ;
      ram_Size  <= SIZE_BYTE;
      ram_A     <= '0;
      ram_DI    <= '0;
      if_ack    <= 1'b0;
      mem_ack   <= 1'b0;
      mem_err   <= 1'b0;
      if_rdata  <= '0;
      mem_rdata <= '0;
    end else begin
      if_ack  <= 1'b0;
      mem_ack <= 1'b0;
      mem_err <= 1'b0;
      case (state)
        ST_IDLE, ST_RESP: begin
          ram_E <= 1'b0;
          if (gnt_mem) begin
            owner    <= OWN_MEM;
            ram_A    <= mem_addr;
            ram_RW   <= mem_rw;
            ram_Size <= mem_size;
            ram_DI   <= mem_wdata;
            // A misaligned word never reaches the RAM: answer with an error at once.
            if (misaligned) begin
              state   <= ST_RESP;
              mem_ack <= 1'b1;
              mem_err <= 1'b1;
            end else begin
              state <= ST_ACC;
              ram_E <= 1'b1;
            end
          end else if (gnt_if) begin
            owner    <= OWN_IF;
            ram_A    <= if_addr;
            ram_RW   <= RW_READ;
            ram_Size <= SIZE_WORD;
            state    <= ST_ACC;
            ram_E    <= 1'b1;
          end else begin
            state <= ST_IDLE;
          end
        end
        ST_ACC: begin
          if (lat_done) begin
            ram_E <= 1'b0;
            state <= ST_RESP;
            if (owner == OWN_MEM) begin
              mem_ack <= 1'b1;
              if (ram_RW == RW_READ) begin
                mem_rdata <= ram_DO;
              end
            end else begin
              if_ack   <= 1'b1;
              if_rdata <= ram_DO;
            end
          end
        end
        default: begin
          state <= ST_IDLE;
          ram_E <= 1'b0;
        end
      endcase
    end
  end

  assign stall_if  = if_req && !if_ack;
  assign stall_mem = mem_req && !mem_ack;
  assign busy      = (state != ST_IDLE);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed transaction table, contention and reset
// sequences, then random traffic against a timeline-based reference model.
module tb_mem_port_arbiter;

  localparam int ADDR_W = 8;
  localparam int DATA_W = 32;
  localparam int LAT    = 2;

  logic              clk = 1'b0;
  logic              R;
  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic [DATA_W-1:0] if_rdata;
  logic              if_ack;
  logic              mem_req;
  logic              mem_rw;
  logic              mem_size;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_ack;
  logic              mem_err;
  logic              ram_E;
  logic              ram_RW;
  logic              ram_Size;
  logic [ADDR_W-1:0] ram_A;
  logic [DATA_W-1:0] ram_DI;
  logic [DATA_W-1:0] ram_DO;
  logic              stall_if;
  logic              stall_mem;
  logic              busy;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mem_port_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .LAT(LAT)) dut (
    .clk(clk), .R(R),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ack(if_ack),
    .mem_req(mem_req), .mem_rw(mem_rw), .mem_size(mem_size), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack), .mem_err(mem_err),
    .ram_E(ram_E), .ram_RW(ram_RW), .ram_Size(ram_Size), .ram_A(ram_A),
    .ram_DI(ram_DI), .ram_DO(ram_DO),
    .stall_if(stall_if), .stall_mem(stall_mem), .busy(busy)
  );

  // ram256x8 stand-in: big-endian words, combinational read, write on clock edge
  logic [7:0] ram     [256];
  logic [7:0] ref_mem [256];

  always_comb begin
    if (ram_Size) ram_DO = {ram[ram_A], ram[ram_A + 8'd1], ram[ram_A + 8'd2], ram[ram_A + 8'd3]};
    else          ram_DO = {24'h0, ram[ram_A]};
  end

  always @(posedge clk) begin
    if (ram_E && ram_RW) begin
      if (ram_Size) begin
        ram[ram_A]        <= ram_DI[31:24];
        ram[ram_A + 8'd1] <= ram_DI[23:16];
        ram[ram_A + 8'd2] <= ram_DI[15:8];
        ram[ram_A + 8'd3] <= ram_DI[7:0];
      end else begin
        ram[ram_A] <= ram_DI[7:0];
      end
    end
  end

  function automatic logic [31:0] ref_load(input logic [7:0] a, input logic sz);
    if (sz) return {ref_mem[a], ref_mem[a + 8'd1], ref_mem[a + 8'd2], ref_mem[a + 8'd3]};
    return {24'h0, ref_mem[a]};
  endfunction

  task automatic ref_store(input logic [7:0] a, input logic sz, input logic [31:0] d);
    if (sz) begin
      ref_mem[a] = d[31:24]; ref_mem[a + 8'd1] = d[23:16];
      ref_mem[a + 8'd2] = d[15:8]; ref_mem[a + 8'd3] = d[7:0];
    end else begin
      ref_mem[a] = d[7:0];
    end
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic chk1(input string nm, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b (t=%0t)", nm, act, exp, $time);
    end
  endtask

  typedef struct {
    bit          is_mem;
    bit          rw;
    bit          size;
    logic [7:0]  addr;
    logic [31:0] wdata;
    int          lat;
    int          ecnt;
    logic [31:0] data;
    bit          err;
  } txn_t;

  txn_t tbl [10];

  task automatic run_txn(input txn_t t, input int idx);
    int n, ecnt;
    bit got;
    logic [7:0] a0;
    logic rw0, sz0;
    if (t.is_mem) begin
      mem_req = 1'b1; mem_rw = t.rw; mem_size = t.size; mem_addr = t.addr; mem_wdata = t.wdata;
    end else begin
      if_req = 1'b1; if_addr = t.addr;
    end
    n = 0; ecnt = 0; got = 1'b0; a0 = 8'h00; rw0 = 1'b0; sz0 = 1'b0;
    while (!got && n < 20) begin
      @(negedge clk);
      n++;
      if (ram_E) begin
        if (ecnt == 0) begin a0 = ram_A; rw0 = ram_RW; sz0 = ram_Size; end
        ecnt++;
      end
      got = t.is_mem ? mem_ack : if_ack;
    end
    chk($sformatf("txn%0d_latency", idx), n, t.lat);
    chk($sformatf("txn%0d_ram_E_cycles", idx), ecnt, t.ecnt);
    if (t.ecnt > 0) begin
      chk($sformatf("txn%0d_ram_A", idx), {24'h0, a0}, {24'h0, t.addr});
      chk1($sformatf("txn%0d_ram_RW", idx), rw0, t.is_mem ? t.rw : 1'b0);
      chk1($sformatf("txn%0d_ram_Size", idx), sz0, t.is_mem ? t.size : 1'b1);
    end
    chk($sformatf("txn%0d_rdata", idx), t.is_mem ? mem_rdata : if_rdata, t.data);
    chk1($sformatf("txn%0d_mem_err", idx), mem_err, t.err);
    chk1($sformatf("txn%0d_other_ack", idx), t.is_mem ? if_ack : mem_ack, 1'b0);
    if (t.is_mem) mem_req = 1'b0; else if_req = 1'b0;
    if (t.is_mem && t.rw && !t.err) ref_store(t.addr, t.size, t.wdata);
    @(negedge clk);
    chk1($sformatf("txn%0d_idle_after", idx), busy, 1'b0);
  endtask

  task automatic new_if();
    if_req  = 1'b1;
    if_addr = 8'($urandom_range(63, 0)) << 2;
  endtask

  task automatic new_mem();
    mem_req   = 1'b1;
    mem_rw    = ($urandom_range(2, 0) == 0);
    mem_size  = ($urandom_range(1, 0) == 1);
    mem_wdata = $urandom;
    mem_addr  = mem_rw ? 8'($urandom_range(255, 64)) : 8'($urandom_range(255, 0));
    if (mem_size && $urandom_range(7, 0) != 0) mem_addr[1:0] = 2'b00;
  endtask

  // Reference model: each access is a time window [grant, ack] computed from the
  // grant rules; expected outputs follow from where the current edge falls.
  task automatic rand_phase(input int cycles, input logic [31:0] if_rd0, input logic [31:0] mem_rd0);
    int e, g_e, ack_e;
    bit have, own_mem, m_err, m_rw, m_size, msk, x_e, x_ifa, x_mema;
    logic [7:0]  m_addr;
    logic [31:0] m_data, m_wdata, x_if, x_mem;
    e = 0; have = 1'b0; g_e = 0; ack_e = 0; own_mem = 1'b0; m_err = 1'b0;
    m_rw = 1'b0; m_size = 1'b0; m_addr = 8'h0; m_data = 32'h0; m_wdata = 32'h0;
    x_if = if_rd0; x_mem = mem_rd0;
    for (int c = 0; c < cycles; c++) begin
      @(negedge clk);
      e++;
      if (!have || e > ack_e) begin
        msk = have && (e == ack_e + 1);
        if (mem_req && !(msk && own_mem)) begin
          have = 1'b1; own_mem = 1'b1; g_e = e;
          m_addr = mem_addr; m_rw = mem_rw; m_size = mem_size; m_wdata = mem_wdata;
          m_err = mem_size && (mem_addr[1:0] != 2'b00);
          ack_e = m_err ? e : e + LAT;
          if (!m_err) begin
            if (mem_rw) ref_store(mem_addr, mem_size, mem_wdata);
            else m_data = ref_load(mem_addr, mem_size);
          end
        end else if (if_req && !(msk && !own_mem)) begin
          have = 1'b1; own_mem = 1'b0; g_e = e;
          m_addr = if_addr; m_rw = 1'b0; m_size = 1'b1; m_err = 1'b0;
          ack_e = e + LAT;
          m_data = ref_load(if_addr, 1'b1);
        end
      end
      x_e    = have && !m_err && e >= g_e && e < g_e + LAT;
      x_ifa  = have && !own_mem && e == ack_e;
      x_mema = have && own_mem && e == ack_e;
      if (x_ifa) x_if = m_data;
      if (x_mema && !m_err && !m_rw) x_mem = m_data;
      chk1("rnd_if_ack", if_ack, x_ifa);
      chk1("rnd_mem_ack", mem_ack, x_mema);
      chk1("rnd_mem_err", mem_err, x_mema && m_err);
      chk1("rnd_ram_E", ram_E, x_e);
      chk1("rnd_busy", busy, have && e >= g_e && e <= ack_e);
      chk1("rnd_stall_if", stall_if, if_req && !x_ifa);
      chk1("rnd_stall_mem", stall_mem, mem_req && !x_mema);
      chk("rnd_if_rdata", if_rdata, x_if);
      chk("rnd_mem_rdata", mem_rdata, x_mem);
      if (x_e) begin
        chk("rnd_ram_A", {24'h0, ram_A}, {24'h0, m_addr});
        chk1("rnd_ram_RW", ram_RW, m_rw);
        chk1("rnd_ram_Size", ram_Size, m_size);
        if (m_rw) chk("rnd_ram_DI", ram_DI, m_wdata);
      end
      // requesters: hold until ack, then renew or drop; occasionally abandon early
      if (if_req) begin
        if (if_ack) begin
          if ($urandom_range(1, 0) == 1) new_if(); else if_req = 1'b0;
        end else if ($urandom_range(15, 0) == 0) begin
          if_req = 1'b0;
        end
      end else if ($urandom_range(3, 0) == 0) begin
        new_if();
      end
      if (mem_req) begin
        if (mem_ack) begin
          if ($urandom_range(1, 0) == 1) new_mem(); else mem_req = 1'b0;
        end
      end else if ($urandom_range(2, 0) == 0) begin
        new_mem();
      end
    end
    if_req = 1'b0; mem_req = 1'b0;
    repeat (LAT + 3) @(negedge clk);
  endtask

  initial begin
    int n, m1, m2, i1, mism, ecnt;
    bit got, saw_e;
    logic [31:0] d1, d2, di;

    for (int i = 0; i < 256; i++) begin ram[i] = 8'h00; ref_mem[i] = 8'h00; end
    ram[8'h04] = 8'hE0; ram[8'h05] = 8'h81; ram[8'h06] = 8'h10; ram[8'h07] = 8'h02;
    ram[8'h23] = 8'h2A;
    for (int i = 0; i < 256; i++) ref_mem[i] = ram[i];

    tbl[0] = '{1'b0, 1'b0, 1'b1, 8'h04, 32'h0,        3, 2, 32'hE0811002, 1'b0};
    tbl[1] = '{1'b1, 1'b0, 1'b1, 8'h20, 32'h0,        3, 2, 32'h0000002A, 1'b0};
    tbl[2] = '{1'b1, 1'b1, 1'b0, 8'h41, 32'h000000AB, 3, 2, 32'h0000002A, 1'b0};
    tbl[3] = '{1'b1, 1'b0, 1'b0, 8'h41, 32'h0,        3, 2, 32'h000000AB, 1'b0};
    tbl[4] = '{1'b1, 1'b0, 1'b1, 8'h22, 32'h0,        1, 0, 32'h000000AB, 1'b1};
    tbl[5] = '{1'b1, 1'b1, 1'b1, 8'h40, 32'h11223344, 3, 2, 32'h000000AB, 1'b0};
    tbl[6] = '{1'b1, 1'b0, 1'b1, 8'h40, 32'h0,        3, 2, 32'h11223344, 1'b0};
    tbl[7] = '{1'b1, 1'b0, 1'b0, 8'h43, 32'h0,        3, 2, 32'h00000044, 1'b0};
    tbl[8] = '{1'b0, 1'b0, 1'b1, 8'h20, 32'h0,        3, 2, 32'h0000002A, 1'b0};
    tbl[9] = '{1'b1, 1'b0, 1'b0, 8'h05, 32'h0,        3, 2, 32'h00000081, 1'b0};

    R = 1'b1; if_req = 1'b0; if_addr = 8'h0; mem_req = 1'b0; mem_rw = 1'b0;
    mem_size = 1'b0; mem_addr = 8'h0; mem_wdata = 32'h0;

    // reset, then idle with no requests
    repeat (2) @(negedge clk);
    chk("reset_outputs", {27'h0, if_ack, mem_ack, mem_err, ram_E, busy}, 32'h0);
    chk("reset_if_rdata", if_rdata, 32'h0);
    chk("reset_mem_rdata", mem_rdata, 32'h0);
    chk("reset_ram_A", {24'h0, ram_A}, 32'h0);
    R = 1'b0;
    saw_e = 1'b0;
    repeat (4) begin
      @(negedge clk);
      saw_e |= ram_E | busy | if_ack | mem_ack;
    end
    chk1("idle_quiet", saw_e, 1'b0);

    for (int i = 0; i < 10; i++) run_txn(tbl[i], i);

    // contention: MEM first, then IF, then MEM again while MEM keeps requesting
    mem_req = 1'b1; mem_rw = 1'b0; mem_size = 1'b1; mem_addr = 8'h20;
    if_req = 1'b1; if_addr = 8'h04;
    n = 0; m1 = 0; m2 = 0; i1 = 0; d1 = 32'h0; d2 = 32'h0; di = 32'h0;
    while (n < 15 && (m2 == 0 || i1 == 0)) begin
      @(negedge clk);
      n++;
      if (n == 1) chk1("cont_stall_if_k", stall_if, 1'b1);
      if (n == 4) chk("cont_if_grant_A", {23'h0, ram_E, ram_A}, {23'h0, 1'b1, 8'h04});
      if (mem_ack) begin
        if (m1 == 0) begin
          m1 = n; d1 = mem_rdata; mem_addr = 8'h05; mem_size = 1'b0;
        end else begin
          m2 = n; d2 = mem_rdata; mem_req = 1'b0;
        end
      end
      if (if_ack) begin i1 = n; di = if_rdata; if_req = 1'b0; end
    end
    chk("cont_mem1_cycle", m1, 3);
    chk("cont_mem1_data", d1, 32'h0000002A);
    chk("cont_if_cycle", i1, 6);
    chk("cont_if_data", di, 32'hE0811002);
    chk("cont_mem2_cycle", m2, 9);
    chk("cont_mem2_data", d2, 32'h00000081);
    repeat (2) @(negedge clk);

    // reset in the middle of an IF access aborts it without an ack
    if_req = 1'b1; if_addr = 8'h04;
    @(negedge clk);
    chk1("rst_abort_ram_E_on", ram_E, 1'b1);
    R = 1'b1;
    @(negedge clk);
    chk("rst_abort_state", {29'h0, ram_E, busy, if_ack}, 32'h0);
    chk("rst_abort_if_rdata", if_rdata, 32'h0);
    chk("rst_abort_mem_rdata", mem_rdata, 32'h0);
    R = 1'b0;
    n = 0; got = 1'b0; ecnt = 0;
    while (!got && n < 10) begin
      @(negedge clk);
      n++;
      if (ram_E) ecnt++;
      got = if_ack;
    end
    chk("rst_regrant_latency", n, 3);
    chk("rst_regrant_ram_E", ecnt, 2);
    chk("rst_regrant_data", if_rdata, 32'hE0811002);
    if_req = 1'b0;
    repeat (2) @(negedge clk);

    rand_phase(3000, 32'hE0811002, 32'h0);

    mism = 0;
    for (int i = 0; i < 256; i++) if (ram[i] !== ref_mem[i]) mism++;
    chk("ram_contents", mism, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
